seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
Parametrised serial sequence detector, the successor to the fixed 2-bit Mealy detector FSM.
- Matches a runtime-loadable PAT_W-bit pattern on a 1-bit qualified input stream.
- Supports overlapping and non-overlapping match modes.
- Emits a registered one-cycle match pulse and keeps a saturating match count.
- Sits between the serial input front end and the status/monitor logic.

Parameters:
PAT_W, 4, pattern length in bits (>= 2)
CNT_W, 8, width of match counter (>= 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  input sample valid; inp is sampled only when en=1
inp  in  1  serial data bit; the newest bit becomes the LSB of the history
cfg_load  in  1  capture pat into the pattern register; restart detection
pat  in  PAT_W  pattern to capture; pat[PAT_W-1] is the oldest bit
ovl  in  1  1 = overlapping matches allowed, 0 = non-overlapping
clr  in  1  synchronous clear of match_cnt
match  out  1  registered one-cycle pulse per detected match
match_cnt  out  CNT_W  saturating count of matches
state_o  out  2  current FSM state (IDLE=0, FILL=1, RUN=2)

Behaviour:
- Reset is asynchronous on rst and applies immediately, even mid-stream. Reset values:
  - state = IDLE
  - pat_q, hist, fill_cnt = 0
  - match = 0, match_cnt = 0
- State register holds IDLE, FILL or RUN.
  - IDLE: no pattern loaded; en and inp ignored; match stays 0.
  - FILL: fewer than PAT_W valid bits collected since the last load or the last non-overlap match.
  - RUN: history holds PAT_W valid bits.
- cfg_load=1 (any state):
  - pat_q <= pat; hist <= 0; fill_cnt <= 0; state <= FILL.
  - An en/inp presented in the same cycle is dropped.
  - match <= 0 in that cycle.
- en=1, state in {FILL, RUN}, no cfg_load:
  - nh = {hist[PAT_W-2:0], inp}; hist <= nh.
  - fill_cnt <= min(fill_cnt+1, PAT_W).
  - Hit when (fill_cnt+1 >= PAT_W) and nh == pat_q.
- On a hit:
  - match <= 1 for exactly one cycle. Latency is 1: the pulse is visible in the cycle after the sampling edge.
  - match_cnt increments, saturating at 2^CNT_W-1.
  - ovl=1: state <= RUN; the history is kept, so the next match may reuse bits.
  - ovl=0: fill_cnt <= 0; hist <= 0; state <= FILL.
- No hit, FILL: state <= RUN once fill_cnt reaches PAT_W.
- en=0: hist, fill_cnt and state hold; match <= 0.
- ovl is sampled on each hit only; changing it between samples is legal.
- clr=1 sets match_cnt <= 0. clr wins over a simultaneous hit: the count becomes 0, but match still pulses.
- fill_cnt is $clog2(PAT_W+1) bits wide. All compares are unsigned.

Optional Feature:
Macro: SEQDET_MEALY_EN
- Defined:
  - Adds output port match_comb (1 bit), a combinational Mealy-style hit: en & (state != IDLE) & ~cfg_load & hit.
  - It is asserted in the same cycle as the completing bit, one cycle ahead of match.
  - Adds no registers.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package seqdet_pkg holds:
  - state typedef (2-bit enum IDLE/FILL/RUN)
  - state encoding constants
  - function sat_inc(value, max)
- One sub-module, seqdet_sat_cnt: CNT_W saturating counter with inc/clr inputs and clr priority. The shift/compare logic and FSM stay in the top module.

Test Plan (PAT_W=4, CNT_W=8 unless stated):
1. cfg_load pat=4'b1011, ovl=1, then en=1 stream 1,0,1,1,0,1,1 -> match pulses the cycle after bit 4 and after bit 7; match_cnt=2; state_o=RUN.
2. Same stream with ovl=0 -> one match, after bit 4 only; state_o=FILL after the match; match_cnt=1.
3. Stream 1,0,1,1 with en=0 idle cycles inserted between every bit -> single match after the 4th valid bit; no pulse during idle cycles.
4. No cfg_load after reset, inp toggling with en=1 for 16 cycles -> match=0, match_cnt=0, state_o=IDLE throughout.
5. CNT_W=2, ovl=1, stream 1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1 (5 matches) -> match_cnt saturates at 3. clr asserted together with the next hit -> match=1, match_cnt=0. cfg_load asserted together with en -> that sample is dropped and fill restarts at 0.
6. rst pulsed asynchronously between clock edges after 3 of the 4 pattern bits -> all outputs 0 immediately and state_o=IDLE. After re-load, a fresh 1011 is needed for a match.

Source files
------------

// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared types and helpers for the serial sequence detector.
// State encoding and a saturating-increment helper.
package seqdet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] value,
    input logic [31:0] max
  );
    return (value >= max) ? max : value + 32'd1;
  endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// seqdet_sat_cnt: CNT_W saturating match counter.
// clr has priority over inc.
module seqdet_sat_cnt
  import seqdet_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= CNT_W'(sat_inc(32'(cnt), 32'(MAX)));
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable PAT_W-bit serial pattern detector.
// Define SEQDET_MEALY_EN to add the combinational match_comb output.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inp,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat,
  input  logic             ovl,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state_o
`ifdef SEQDET_MEALY_EN
  ,
  output logic             match_comb
`endif
);

  localparam int FW = $clog2(PAT_W + 1);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  // Only the newest PAT_W-1 bits need storing; inp completes the window.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_d;

  logic [PAT_W-1:0] nh;
  logic [FW-1:0]    fill_nx;
  logic             act;
  logic             hit;

  assign nh      = {hist_q, inp};
  assign fill_nx = FW'(sat_inc(32'(fill_q), 32'(PAT_W)));
  assign act     = en & (state_q != IDLE) & ~cfg_load;
  assign hit     = act
                 & (32'(fill_q) + 32'd1 >= 32'(PAT_W))
                 & (nh == pat_q);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    unique case (1'b1)
      cfg_load: begin
        pat_d   = pat;
        hist_d  = '0;
        fill_d  = '0;
        state_d = FILL;
      end
      hit & ~ovl: begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = FILL;
        match_d = 1'b1;
      end
      hit & ovl: begin
        hist_d  = nh[PAT_W-2:0];
        fill_d  = fill_nx;
        state_d = RUN;
        match_d = 1'b1;
      end
      act & ~hit: begin
        hist_d  = nh[PAT_W-2:0];
        fill_d  = fill_nx;
        if (fill_nx == FW'(PAT_W)) begin
          state_d = RUN;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      match   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match   <= match_d;
    end
  end

  seqdet_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (clr),
    .cnt (match_cnt)
  );

  assign state_o = state_q;

`ifdef SEQDET_MEALY_EN
  assign match_comb = hit;
`endif

endmodule
